// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: generates SCLK plus launch/sample/done strobes for one character.
// Optional feature macro SPI_SCLK_GAP_EN adds a programmable setup/hold gap around the SCLK burst.
module spi_sclk_engine #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 7
) (
    input  logic             wb_clk_in,
    input  logic             wb_rst_n,
    input  logic             go,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] divider,
    input  logic [LEN_W-1:0] char_len,
`ifdef SPI_SCLK_GAP_EN
    input  logic [7:0]       gap,
`endif
    output logic             sclk_out,
    output logic             tip,
    output logic             launch,
    output logic             sample,
    output logic             done,
    output logic [LEN_W-1:0] bit_cnt
);

    localparam int TOG_W = LEN_W + 1;
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [TOG_W-1:0] TOG_ONE = TOG_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

`ifdef SPI_SCLK_GAP_EN
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic [LEN_W-1:0]   len_q;
    logic               cpol_q, cpha_q;
    logic [DIV_W-1:0]   hp_cnt_q, hp_cnt_d;
    logic [TOG_W-1:0]   tog_cnt_q, tog_cnt_d;
    logic [LEN_W-1:0]   bit_cnt_d;
    logic               sclk_d, tip_d, launch_d, sample_d, done_d;
    logic               cfg_load;
    logic [TOG_W-1:0]   last_tog;
    logic               leading, is_last, hp_hit;
`ifdef SPI_SCLK_GAP_EN
    logic [7:0]         gap_q;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               gap_hit;
`endif

    // Toggle index of the final edge is 2N-1; char_len=0 wraps to all-ones, i.e. 2*2**LEN_W-1.
    assign last_tog = {len_q, 1'b0} - TOG_ONE;
    assign leading  = ~tog_cnt_q[0];
    assign is_last  = (tog_cnt_q == last_tog);
    assign hp_hit   = (hp_cnt_q == div_q);
`ifdef SPI_SCLK_GAP_EN
    assign gap_hit  = (gap_cnt_q == gap_q - 8'd1);
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q;
        tog_cnt_d = tog_cnt_q;
        bit_cnt_d = bit_cnt;
        sclk_d    = sclk_out;
        tip_d     = tip;
        launch_d  = 1'b0;
        sample_d  = 1'b0;
        done_d    = 1'b0;
        cfg_load  = 1'b0;
`ifdef SPI_SCLK_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (go) begin
                    cfg_load  = 1'b1;
                    tip_d     = 1'b1;
                    hp_cnt_d  = '0;
                    tog_cnt_d = '0;
                    bit_cnt_d = '0;
                    launch_d  = ~cpha;
`ifdef SPI_SCLK_GAP_EN
                    gap_cnt_d = '0;
                    state_d   = (gap != 8'd0) ? SETUP : SHIFT;
`else
                    state_d   = SHIFT;
`endif
                end
            end

`ifdef SPI_SCLK_GAP_EN
            SETUP: begin
                if (gap_hit) begin
                    state_d  = SHIFT;
                    hp_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
`endif

            SHIFT: begin
                if (hp_hit) begin
                    hp_cnt_d  = '0;
                    tog_cnt_d = tog_cnt_q + TOG_ONE;
                    // Odd toggles move away from the idle level, even toggles return to it.
                    sclk_d    = cpol_q ^ leading;
                    sample_d  = leading ^ cpha_q;
                    launch_d  = cpha_q ? leading : (~leading & ~is_last);
                    if (leading ^ cpha_q) begin
                        bit_cnt_d = bit_cnt + LEN_ONE;
                    end
                    if (is_last) begin
`ifdef SPI_SCLK_GAP_EN
                        if (gap_q != 8'd0) begin
                            state_d   = HOLD;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                            tip_d   = 1'b0;
                            done_d  = 1'b1;
                        end
`else
                        state_d = IDLE;
                        tip_d   = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_ONE;
                end
            end

`ifdef SPI_SCLK_GAP_EN
            HOLD: begin
                if (gap_hit) begin
                    state_d = IDLE;
                    tip_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            len_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            hp_cnt_q  <= '0;
            tog_cnt_q <= '0;
            bit_cnt   <= '0;
            sclk_out  <= 1'b0;
            tip       <= 1'b0;
            launch    <= 1'b0;
            sample    <= 1'b0;
            done      <= 1'b0;
`ifdef SPI_SCLK_GAP_EN
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            tog_cnt_q <= tog_cnt_d;
            bit_cnt   <= bit_cnt_d;
            sclk_out  <= sclk_d;
            tip       <= tip_d;
            launch    <= launch_d;
            sample    <= sample_d;
            done      <= done_d;
            if (cfg_load) begin
                div_q  <= divider;
                len_q  <= char_len;
                cpol_q <= cpol;
                cpha_q <= cpha;
            end
`ifdef SPI_SCLK_GAP_EN
            gap_cnt_q <= gap_cnt_d;
            if (cfg_load) begin
                gap_q <= gap;
            end
`endif
        end
    end

endmodule

// File: doc/spi_sclk_engine.md
SPI_SCLK_ENGINE -- requirements
Module: spi_sclk_engine

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the half-period divider.
REQ-002 SHALL have parameter LEN_W, default 7, width of the character-length field.
REQ-003 SHALL have port wb_clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port go  input  1  start request, sampled only while tip=0.
REQ-006 SHALL have port cpol  input  1  SCLK idle level.
REQ-007 SHALL have port cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-008 SHALL have port divider  input  DIV_W  half period = divider+1 wb_clk_in cycles.
REQ-009 SHALL have port char_len  input  LEN_W  bits per transfer; 0 means 2**LEN_W.
REQ-010 SHALL have port sclk_out  output  1  serial clock.
REQ-011 SHALL have port tip  output  1  transfer in progress.
REQ-012 SHALL have port launch  output  1  one-cycle strobe: drive next MOSI bit.
REQ-013 SHALL have port sample  output  1  one-cycle strobe: capture MISO bit.
REQ-014 SHALL have port done  output  1  one-cycle end-of-transfer pulse.
REQ-015 SHALL have port bit_cnt  output  LEN_W  bits sampled so far in current transfer, wraps modulo 2**LEN_W.

Function
REQ-016 SHALL implement states IDLE and SHIFT (plus SETUP/HOLD per REQ-031); IDLE->SHIFT on go, SHIFT->IDLE after final edge.
REQ-017 SHALL, at the edge accepting go (E0), latch divider, char_len, cpol, cpha, set tip=1, clear half-period counter and bit_cnt.
REQ-018 SHALL ignore go while tip=1 and ignore changes to divider/char_len/cpol/cpha during a transfer.
REQ-019 SHALL, in IDLE, drive sclk_out to the current cpol value, registered (follows cpol one cycle later).
REQ-020 SHALL toggle sclk_out at edges E0+k*(divider+1), k=1..2N (N = effective bit count); divider=0 toggles every cycle.
REQ-021 SHALL end with sclk_out equal to latched cpol; odd toggles are leading edges, even toggles trailing edges.
REQ-022 SHALL assert launch/sample registered in the same cycle sclk_out takes its new value.
REQ-023 SHALL, for cpha=0: assert launch at E0 and on every trailing edge except the last; sample on every leading edge.
REQ-024 SHALL, for cpha=1: assert launch on every leading edge; sample on every trailing edge.
REQ-025 SHALL increment bit_cnt on each sample strobe; exactly N sample and N launch strobes per transfer.
REQ-026 SHALL assert done for one cycle and drop tip at the edge of the 2N-th toggle; total tip time 2N*(divider+1) cycles.
REQ-027 SHALL accept a go held high during the done cycle at the next edge (back-to-back, no idle gap required).
REQ-028 SHALL use a DIV_W-bit counter compared for equality with latched divider; divider=all-ones SHALL be supported without overflow.

Reset
REQ-029 SHALL, while wb_rst_n=0, force sclk_out=0, tip=0, launch=0, sample=0, done=0, bit_cnt=0, state IDLE, counters 0.
REQ-030 SHALL abort any transfer on reset without emitting done; after release, sclk_out follows cpol per REQ-019.

Configuration
REQ-031 SHALL, when macro SPI_SCLK_GAP_EN is defined, add input gap (8 bits) and states SETUP/HOLD: gap cycles after E0 before the half-period counter starts, gap cycles after the final edge before done; tip high throughout.
REQ-032 SHALL, when SPI_SCLK_GAP_EN is undefined, omit the gap port and SETUP/HOLD states with timing identical to gap=0.

Verification
REQ-033 SHALL verify divider=0, char_len=8, cpol=0, cpha=0: 16 toggles on consecutive cycles, tip 16 cycles, 8 samples on rising edges, launch at E0 plus 7, one done.
REQ-034 SHALL verify divider=3, char_len=8, cpol=1, cpha=1: sclk idles high, 4-cycle half period, tip 64 cycles, launch on falling, sample on rising edges.
REQ-035 SHALL verify char_len=0 with LEN_W=7: 256 toggles, 128 samples, bit_cnt wraps to 0, single done.
REQ-036 SHALL verify go pulsed and divider changed 3->0 mid-transfer: no restart, timing unchanged; go held in done cycle starts next transfer immediately.
REQ-037 SHALL verify wb_rst_n low at toggle 5 of 16: all outputs 0 asynchronously, no done; sclk_out=cpol one cycle after release.
REQ-038 SHALL verify with SPI_SCLK_GAP_EN, gap=2, divider=1, char_len=1: first toggle at E0+4, done at E0+8, tip 8 cycles.
